reg_pipe: RTL and testbench
===========================

// Module: reg_pipe
// PURPOSE
//  Parametrised elastic pipeline register: DEPTH stages of signed WIDTH-bit data, each stage with its own valid bit.
//  Valid/ready handshake on both sides, bubble-collapsing, global enable (stall) and synchronous flush.
//  Generalises the plain enable/reset register into a back-pressure-aware retiming chain between datapath units.
// PARAMETERS
//  WIDTH   32  data width in bits (signed)
//  DEPTH   2   number of register stages, >=1
// PORTS
//  clk        in   1                   clock, all state updates on posedge
//  rst        in   1                   reset, synchronous, active-high
//  en         in   1                   global enable; 0 = freeze whole pipe
//  flush      in   1                   synchronous clear of all stage valids
//  in_valid   in   1                   upstream data valid
//  in_ready   out  1                   pipe can accept in_data this cycle
//  in_data    in   WIDTH (signed)      upstream data
//  out_valid  out  1                   out_data valid
//  out_ready  in   1                   downstream accepts this cycle
//  out_data   out  WIDTH (signed)      data of last stage
//  occupancy  out  $clog2(DEPTH+1)     valid-stage count (REG_PIPE_OCC_EN only)
// BEHAVIOUR
//  - Stage i holds v[i], d[i]; stage 0 is input side, stage DEPTH-1 drives out_valid/out_data.
//  - Reset (rst=1 at posedge): all v[i]=0, all d[i]=0; rst overrides en and flush.
//  - out_valid = v[DEPTH-1] & en; out_data = d[DEPTH-1] (regardless of en).
//  - Output transfer: out_valid & out_ready. Input transfer: in_valid & in_ready.
//  - Stage ready chain: rdy[DEPTH-1] = !v[DEPTH-1] | out_ready; rdy[i] = !v[i] | rdy[i+1].
//  - in_ready = en & !flush & !rst & rdy[0]. Path out_ready -> in_ready is combinational (decided).
//  - When en=1 and flush=0: stage i (i>0) loads d[i-1] and v[i]<=v[i-1] when rdy[i]; stage 0 loads in_data and v[0]<=in_valid when rdy[0].
//    A stage not ready holds its d/v. d[i] updates only when its incoming valid is 1 (no toggling on bubbles).
//  - Bubbles collapse: a non-valid stage never blocks upstream.
//  - Latency with no back-pressure: word accepted at edge k is on out_data with out_valid=1 after edge k+DEPTH-1.
//  - Throughput: 1 word/cycle sustained; full pipe with out_ready=1 accepts and emits in the same cycle.
//  - Full (all v=1) and out_ready=0: in_ready=0, contents held unchanged.
//  - en=0: no stage moves, in_ready=0, out_valid=0; contents preserved and reappear when en returns to 1.
//  - flush=1 (en ignored): all v<=0 next edge, d held; in_ready=0 so no input is taken that cycle;
//    out_valid still reflects current state, but any output transfer that cycle counts as the last beat.
//  - Ordering: words leave in acceptance order; no drop or duplication except by flush/rst.
//  - DEPTH=1 degenerates to a single valid-tagged register with combinational pass-through of ready.
// CONFIGURATION
//  - REG_PIPE_OCC_EN defined: occupancy port present; registered popcount of v[], reset 0,
//    +1 on input transfer only, -1 on output transfer only, unchanged on both/neither, 0 after flush.
//  - REG_PIPE_OCC_EN undefined: occupancy port and counter absent; all other behaviour identical.
// STRUCTURE
//  - Shared util header (guarded `ifndef): CLOG2 helper macro, common handshake width constants.
//  - Sub-module reg_pipe_stage: one valid+data stage (ports clk, rst, en, flush, in_v, in_d, rdy_nxt, v, d, rdy);
//    reg_pipe instantiates DEPTH of these in a generate loop and adds the optional counter.
// TESTING  (WIDTH=32, DEPTH=3 unless stated)
//  1 Reset: rst=1 with random stage contents -> next cycle out_valid=0, out_data=0, in_ready=1 (en=1).
//  2 Streaming: in_valid=1, data 1,2,3,... out_ready=1 -> out_valid at edge 3, out_data 1,2,3,... one per cycle.
//  3 Back-pressure: out_ready=0, push -5,7,9 -> in_ready=0 after 3 accepted; release -> -5,7,9 in order, no loss.
//  4 Bubbles: push 0xA, idle 2 cycles, push 0xB with out_ready=0 -> both collapse into stages 2,1; occupancy=2 (OCC_EN).
//  5 Stall/flush: full pipe, en=0 for 4 cycles -> out_valid=0, contents held; flush=1 -> out_valid=0 next cycle, occupancy=0.
//  6 Simultaneous: full pipe, in_valid=1 and out_ready=1 -> accept and emit same cycle, occupancy stays 3; repeat with DEPTH=1.

Source files
------------

// File: rtl/reg_pipe_pkg.sv
// ============================================================================
// Module : reg_pipe_pkg
// Brief  : Shared constants, transfer-kind encoding and width helper for the
//          reg_pipe elastic pipeline. Optional feature macro: REG_PIPE_OCC_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef REG_PIPE_UTIL_DEFS
`define REG_PIPE_UTIL_DEFS
`define REG_PIPE_CLOG2(x) ($clog2(x))
`endif

package reg_pipe_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 2;

  // {input transfer, output transfer} packed into one code
  typedef enum logic [1:0] {
    XFER_NONE = 2'b00,
    XFER_OUT  = 2'b01,
    XFER_IN   = 2'b10,
    XFER_BOTH = 2'b11
  } xfer_e;

  function automatic int occ_width(input int depth);
    return `REG_PIPE_CLOG2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_pipe_if.sv
// ============================================================================
// Module : reg_pipe_if
// Brief  : Valid/ready handshake bundle for both sides of reg_pipe.
//          Optional feature macro: REG_PIPE_OCC_EN (no effect on this file).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface reg_pipe_if #(
  parameter int WIDTH = 32
);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_data;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

endinterface

`default_nettype wire

// File: rtl/reg_pipe_stage.sv
// ============================================================================
// Module : reg_pipe_stage
// Brief  : One valid-tagged data register of the elastic pipeline.
//          Optional feature macro: REG_PIPE_OCC_EN (no effect on this file).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_pipe_stage #(
  parameter int WIDTH = 32
) (
  input  wire logic                    clk,
  input  wire logic                    rst,
  input  wire logic                    en,
  input  wire logic                    flush,
  input  wire logic                    in_v,
  input  wire logic signed [WIDTH-1:0] in_d,
  input  wire logic                    rdy_nxt,
  output logic                         v,
  output logic signed [WIDTH-1:0]      d,
  output logic                         rdy
);

  // An empty stage always accepts, so bubbles never block upstream
  assign rdy = ~v | rdy_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      v <= 1'b0;
      d <= '0;
    end else if (flush) begin
      v <= 1'b0;
    end else if (en && rdy) begin
      v <= in_v;
      if (in_v) begin
        d <= in_d;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_pipe.sv
// ============================================================================
// Module : reg_pipe
// Brief  : DEPTH-stage elastic pipeline register with stall, flush and
//          optional occupancy counter (enabled by macro REG_PIPE_OCC_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_pipe
  import reg_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic en,
  input  wire logic flush,
  reg_pipe_if.slave bus
`ifdef REG_PIPE_OCC_EN
  ,
  output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

  logic [DEPTH-1:0]        v;
  logic [DEPTH-1:0]        rdy;
  logic [DEPTH-1:0]        rdy_nxt;
  logic signed [WIDTH-1:0] d [DEPTH];
  logic                    unused_rdy;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic                    in_v;
      logic signed [WIDTH-1:0] in_d;

      if (i == 0) begin : g_head
        assign in_v = bus.in_valid;
        assign in_d = bus.in_data;
      end else begin : g_body
        assign in_v = v[i-1];
        assign in_d = d[i-1];
      end

      // Downstream readiness flattened: ready unless every later stage is full
      if (i == DEPTH - 1) begin : g_tail
        assign rdy_nxt[i] = bus.out_ready;
      end else begin : g_mid
        assign rdy_nxt[i] = bus.out_ready | ~(&v[DEPTH-1:i+1]);
      end

      reg_pipe_stage #(
        .WIDTH (WIDTH)
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .flush   (flush),
        .in_v    (in_v),
        .in_d    (in_d),
        .rdy_nxt (rdy_nxt[i]),
        .v       (v[i]),
        .d       (d[i]),
        .rdy     (rdy[i])
      );
    end
  endgenerate

  assign unused_rdy    = ^rdy;
  assign bus.in_ready  = en & ~flush & ~rst & rdy[0];
  assign bus.out_valid = v[DEPTH-1] & en;
  assign bus.out_data  = d[DEPTH-1];

`ifdef REG_PIPE_OCC_EN
  logic  in_xfer;
  logic  out_xfer;
  xfer_e xfer;

  always_comb begin
    in_xfer  = bus.in_valid & bus.in_ready;
    out_xfer = bus.out_valid & bus.out_ready;
    xfer     = xfer_e'({in_xfer, out_xfer});
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occupancy <= '0;
    end else begin
      case (xfer)
        XFER_IN:  occupancy <= occupancy + 1'b1;
        XFER_OUT: occupancy <= occupancy - 1'b1;
        default:  occupancy <= occupancy;
      endcase
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_reg_pipe.sv
// ============================================================================
// Module : tb_reg_pipe
// Brief  : Directed self-checking bench for reg_pipe (DEPTH=3 and DEPTH=1).
//          Occupancy checks compiled in with macro REG_PIPE_OCC_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_pipe;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic flush;
  int   total = 0;
  int   bad   = 0;

  reg_pipe_if #(.WIDTH(32)) b3 ();
  reg_pipe_if #(.WIDTH(32)) b1 ();

`ifdef REG_PIPE_OCC_EN
  logic [1:0] occ3;
  logic [0:0] occ1;
`endif

  always #5 clk = ~clk;

  reg_pipe #(.WIDTH(32), .DEPTH(3)) u_dut3 (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .flush (flush),
    .bus   (b3)
`ifdef REG_PIPE_OCC_EN
    ,
    .occupancy (occ3)
`endif
  );

  reg_pipe #(.WIDTH(32), .DEPTH(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .flush (flush),
    .bus   (b1)
`ifdef REG_PIPE_OCC_EN
    ,
    .occupancy (occ1)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    b3.out_ready = 1'b0;
    b3.in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      b3.in_data = 32'(100 + k);
      cyc();
    end
    b3.in_valid = 1'b0;
    #1;
    total++;
    if ({b3.out_valid, b3.out_data} !== {1'b1, 32'sd100})
      begin bad++; $display("FAIL pre_reset_fill got=%0d/%0d want=1/100", b3.out_valid, b3.out_data); end
    rst = 1'b1;
    #1;
    total++;
    if (b3.in_ready !== 1'b0)
      begin bad++; $display("FAIL in_ready_during_rst got=%0b want=0", b3.in_ready); end
    cyc();
    rst = 1'b0;
    #1;
    total++;
    if ({b3.out_valid, b3.out_data} !== {1'b0, 32'sd0})
      begin bad++; $display("FAIL reset_out got=%0d/%0d want=0/0", b3.out_valid, b3.out_data); end
    total++;
    if (b3.in_ready !== 1'b1)
      begin bad++; $display("FAIL reset_in_ready got=%0b want=1", b3.in_ready); end
    total++;
    if (b1.out_valid !== 1'b0)
      begin bad++; $display("FAIL reset_d1_valid got=%0b want=0", b1.out_valid); end
`ifdef REG_PIPE_OCC_EN
    total++;
    if (occ3 !== 2'd0)
      begin bad++; $display("FAIL reset_occ got=%0d want=0", occ3); end
`endif
  endtask

  task automatic test_streaming();
    b3.out_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      b3.in_valid = (c < 8);
      b3.in_data  = 32'(c + 1);
      #1;
      total++;
      if (b3.in_ready !== 1'b1)
        begin bad++; $display("FAIL stream_in_ready c=%0d got=%0b want=1", c, b3.in_ready); end
      total++;
      if (c >= 3) begin
        if ({b3.out_valid, b3.out_data} !== {1'b1, 32'(c - 2)})
          begin bad++; $display("FAIL stream_out c=%0d got=%0d/%0d want=1/%0d", c, b3.out_valid, b3.out_data, c - 2); end
      end else begin
        if (b3.out_valid !== 1'b0)
          begin bad++; $display("FAIL stream_latency c=%0d got=%0b want=0", c, b3.out_valid); end
      end
      cyc();
    end
    b3.in_valid = 1'b0;
    #1;
    total++;
    if (b3.out_valid !== 1'b0)
      begin bad++; $display("FAIL stream_drained got=%0b want=0", b3.out_valid); end
  endtask

  task automatic test_backpressure();
    logic signed [31:0] vals [3];
    vals[0] = -32'sd5; vals[1] = 32'sd7; vals[2] = 32'sd9;
    b3.out_ready = 1'b0;
    b3.in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      b3.in_data = vals[k];
      #1;
      total++;
      if (b3.in_ready !== 1'b1)
        begin bad++; $display("FAIL bp_accept k=%0d got=%0b want=1", k, b3.in_ready); end
      cyc();
    end
    b3.in_data = 32'sd100;
    #1;
    total++;
    if (b3.in_ready !== 1'b0)
      begin bad++; $display("FAIL bp_full_in_ready got=%0b want=0", b3.in_ready); end
    cyc();
    total++;
    if ({b3.out_valid, b3.out_data} !== {1'b1, -32'sd5})
      begin bad++; $display("FAIL bp_held got=%0d/%0d want=1/-5", b3.out_valid, b3.out_data); end
`ifdef REG_PIPE_OCC_EN
    total++;
    if (occ3 !== 2'd3)
      begin bad++; $display("FAIL bp_occ got=%0d want=3", occ3); end
`endif
    b3.in_valid  = 1'b0;
    b3.out_ready = 1'b1;
    #1;
    total++;
    if (b3.in_ready !== 1'b1)
      begin bad++; $display("FAIL bp_comb_ready got=%0b want=1", b3.in_ready); end
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({b3.out_valid, b3.out_data} !== {1'b1, vals[k]})
        begin bad++; $display("FAIL bp_drain k=%0d got=%0d/%0d want=1/%0d", k, b3.out_valid, b3.out_data, vals[k]); end
      cyc();
    end
    total++;
    if (b3.out_valid !== 1'b0)
      begin bad++; $display("FAIL bp_no_dup got=%0b want=0", b3.out_valid); end
  endtask

  task automatic test_bubbles();
    b3.out_ready = 1'b0;
    b3.in_valid  = 1'b1;
    b3.in_data   = 32'sh0A;
    cyc();
    b3.in_valid = 1'b0;
    cyc();
    cyc();
    b3.in_valid = 1'b1;
    b3.in_data  = 32'sh0B;
    #1;
    total++;
    if (b3.in_ready !== 1'b1)
      begin bad++; $display("FAIL bub_in_ready got=%0b want=1", b3.in_ready); end
    cyc();
    b3.in_valid = 1'b0;
    cyc();
    cyc();
    total++;
    if ({b3.out_valid, b3.out_data} !== {1'b1, 32'sh0A})
      begin bad++; $display("FAIL bub_head got=%0d/%0d want=1/10", b3.out_valid, b3.out_data); end
    total++;
    if (b3.in_ready !== 1'b1)
      begin bad++; $display("FAIL bub_room got=%0b want=1", b3.in_ready); end
`ifdef REG_PIPE_OCC_EN
    total++;
    if (occ3 !== 2'd2)
      begin bad++; $display("FAIL bub_occ got=%0d want=2", occ3); end
`endif
    b3.out_ready = 1'b1;
    cyc();
    total++;
    if ({b3.out_valid, b3.out_data} !== {1'b1, 32'sh0B})
      begin bad++; $display("FAIL bub_second got=%0d/%0d want=1/11", b3.out_valid, b3.out_data); end
    cyc();
    total++;
    if (b3.out_valid !== 1'b0)
      begin bad++; $display("FAIL bub_empty got=%0b want=0", b3.out_valid); end
  endtask

  task automatic test_stall_flush();
    b3.out_ready = 1'b0;
    b3.in_valid  = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      b3.in_data = 32'(11 * k);
      cyc();
    end
    en = 1'b0;
    b3.out_ready = 1'b1;
    b3.in_data   = 32'sd77;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++;
      if (b3.in_ready !== 1'b0)
        begin bad++; $display("FAIL stall_in_ready k=%0d got=%0b want=0", k, b3.in_ready); end
      total++;
      if ({b3.out_valid, b3.out_data} !== {1'b0, 32'sd11})
        begin bad++; $display("FAIL stall_out k=%0d got=%0d/%0d want=0/11", k, b3.out_valid, b3.out_data); end
      cyc();
    end
    en = 1'b1;
    b3.in_valid  = 1'b0;
    b3.out_ready = 1'b0;
    #1;
    total++;
    if ({b3.out_valid, b3.out_data} !== {1'b1, 32'sd11})
      begin bad++; $display("FAIL stall_resume got=%0d/%0d want=1/11", b3.out_valid, b3.out_data); end
`ifdef REG_PIPE_OCC_EN
    total++;
    if (occ3 !== 2'd3)
      begin bad++; $display("FAIL stall_occ got=%0d want=3", occ3); end
`endif
    b3.out_ready = 1'b1;
    cyc();
    total++;
    if ({b3.out_valid, b3.out_data} !== {1'b1, 32'sd22})
      begin bad++; $display("FAIL stall_order got=%0d/%0d want=1/22", b3.out_valid, b3.out_data); end
    b3.out_ready = 1'b0;
    cyc();
    flush = 1'b1;
    b3.in_valid = 1'b1;
    b3.in_data  = 32'sd99;
    #1;
    total++;
    if ({b3.in_ready, b3.out_valid} !== 2'b01)
      begin bad++; $display("FAIL flush_cycle got=ready%0b/valid%0b want=ready0/valid1", b3.in_ready, b3.out_valid); end
    cyc();
    flush = 1'b0;
    b3.in_valid = 1'b0;
    #1;
    total++;
    if ({b3.out_valid, b3.out_data} !== {1'b0, 32'sd22})
      begin bad++; $display("FAIL flush_after got=%0d/%0d want=0/22", b3.out_valid, b3.out_data); end
`ifdef REG_PIPE_OCC_EN
    total++;
    if (occ3 !== 2'd0)
      begin bad++; $display("FAIL flush_occ got=%0d want=0", occ3); end
`endif
    b3.in_valid  = 1'b1;
    b3.in_data   = 32'sd44;
    b3.out_ready = 1'b1;
    cyc();
    b3.in_valid = 1'b0;
    cyc();
    total++;
    if (b3.out_valid !== 1'b0)
      begin bad++; $display("FAIL flush_refill_early got=%0b want=0", b3.out_valid); end
    cyc();
    total++;
    if ({b3.out_valid, b3.out_data} !== {1'b1, 32'sd44})
      begin bad++; $display("FAIL flush_refill got=%0d/%0d want=1/44", b3.out_valid, b3.out_data); end
    cyc();
  endtask

  task automatic test_back_to_back();
    b3.out_ready = 1'b0;
    b3.in_valid  = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      b3.in_data = 32'(k);
      cyc();
    end
    b3.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      b3.in_data = 32'(4 + k);
      #1;
      total++;
      if (b3.in_ready !== 1'b1)
        begin bad++; $display("FAIL b2b_in_ready k=%0d got=%0b want=1", k, b3.in_ready); end
      total++;
      if ({b3.out_valid, b3.out_data} !== {1'b1, 32'(1 + k)})
        begin bad++; $display("FAIL b2b_out k=%0d got=%0d/%0d want=1/%0d", k, b3.out_valid, b3.out_data, 1 + k); end
      cyc();
`ifdef REG_PIPE_OCC_EN
      total++;
      if (occ3 !== 2'd3)
        begin bad++; $display("FAIL b2b_occ k=%0d got=%0d want=3", k, occ3); end
`endif
    end
    b3.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if ({b3.out_valid, b3.out_data} !== {1'b1, 32'(4 + k)})
        begin bad++; $display("FAIL b2b_drain k=%0d got=%0d/%0d want=1/%0d", k, b3.out_valid, b3.out_data, 4 + k); end
      cyc();
    end
    total++;
    if (b3.out_valid !== 1'b0)
      begin bad++; $display("FAIL b2b_empty got=%0b want=0", b3.out_valid); end
  endtask

  task automatic test_depth1();
    b1.out_ready = 1'b0;
    b1.in_valid  = 1'b1;
    b1.in_data   = 32'sh55;
    #1;
    total++;
    if (b1.in_ready !== 1'b1)
      begin bad++; $display("FAIL d1_accept got=%0b want=1", b1.in_ready); end
    cyc();
    b1.in_data = 32'sh66;
    #1;
    total++;
    if ({b1.in_ready, b1.out_valid, b1.out_data} !== {2'b01, 32'sh55})
      begin bad++; $display("FAIL d1_full got=r%0b/v%0b/%0d want=r0/v1/85", b1.in_ready, b1.out_valid, b1.out_data); end
    cyc();
    total++;
    if ({b1.out_valid, b1.out_data} !== {1'b1, 32'sh55})
      begin bad++; $display("FAIL d1_held got=%0d/%0d want=1/85", b1.out_valid, b1.out_data); end
    b1.out_ready = 1'b1;
    #1;
    total++;
    if (b1.in_ready !== 1'b1)
      begin bad++; $display("FAIL d1_passthru got=%0b want=1", b1.in_ready); end
    cyc();
    total++;
    if ({b1.out_valid, b1.out_data} !== {1'b1, 32'sh66})
      begin bad++; $display("FAIL d1_swap got=%0d/%0d want=1/102", b1.out_valid, b1.out_data); end
`ifdef REG_PIPE_OCC_EN
    total++;
    if (occ1 !== 1'b1)
      begin bad++; $display("FAIL d1_occ got=%0d want=1", occ1); end
`endif
    b1.in_valid = 1'b0;
    cyc();
    total++;
    if (b1.out_valid !== 1'b0)
      begin bad++; $display("FAIL d1_empty got=%0b want=0", b1.out_valid); end
`ifdef REG_PIPE_OCC_EN
    total++;
    if (occ1 !== 1'b0)
      begin bad++; $display("FAIL d1_occ_empty got=%0d want=0", occ1); end
`endif
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b1;
    flush = 1'b0;
    b3.in_valid = 1'b0; b3.in_data = '0; b3.out_ready = 1'b0;
    b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b0;
    cyc();
    cyc();
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubbles();
    test_stall_flush();
    test_back_to_back();
    test_depth1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

`default_nettype wire
